mul32_seq: RTL and testbench

//  Multi-cycle 32x32->64 multiplier built around one mult18 primitive.

---
 rtl/mul32_seq_pkg.sv | 26 ++
 rtl/mul32_seq_mult18.sv | 12 +
 rtl/mul32_seq.sv | 158 +++++++++++++++
 tb/tb_mul32_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul32_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
//   state_e      : control FSM states
//   HALF         : operand half width fed to the mult18 primitive
//   StepShift    : left shift applied to each step's partial product
//   pp_align()   : places a 32-bit partial product at its step's weight
package mul32_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StFix,
        StDone
    } state_e;

    localparam int unsigned HALF = 16;

    // Step k multiplies {aL*bL, aL*bH, aH*bL, aH*bH}.
    localparam int unsigned StepShift [4] = '{0, 16, 16, 32};

    function automatic logic [63:0] pp_align(input logic [31:0] pp, input logic [1:0] step);
        logic [63:0] wide;
        wide = {32'b0, pp};
        return wide << StepShift[step];
    endfunction

endpackage

// File: rtl/mul32_seq_mult18.sv
// 18x18 -> 36 unsigned multiplier primitive.
//   a_i, b_i : 18-bit unsigned operands
//   p_o      : 36-bit unsigned product
module mul32_seq_mult18 (
    input  logic [17:0] a_i,
    input  logic [17:0] b_i,
    output logic [35:0] p_o
);

    assign p_o = 36'(a_i) * 36'(b_i);

endmodule

// File: rtl/mul32_seq.sv
// Multi-cycle 32x32 -> 64 multiplier built around one mult18 primitive.
// Four multiply steps accumulate 16x16 partial products, then one fix-up step
// applies the two's complement correction to the upper word.
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : operand handshake (in_ready only in idle)
//   in_a, in_b               : operands
//   in_a_signed, in_b_signed : per-operand two's complement flags
//   out_valid/out_ready      : result handshake
//   out_prod                 : 64-bit product, mod 2^64
//   busy                     : operation in flight
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int unsigned PIPE_MULT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_a_signed,
    input  logic        in_b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_prod,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, b_q;
    logic        sa_q, sb_q;
    logic        load;

    // Operand-half select: step[1] picks the a half, step[0] the b half.
    logic [HALF-1:0] op_a, op_b;
    assign op_a = step_q[1] ? a_q[31:16] : a_q[15:0];
    assign op_b = step_q[0] ? b_q[31:16] : b_q[15:0];

    logic [35:0] prod;
    mul32_seq_mult18 u_mult18 (
        .a_i ({2'b00, op_a}),
        .b_i ({2'b00, op_b}),
        .p_o (prod)
    );

    // Upper product bits are structurally zero for 16-bit operands.
    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[35:32];

    logic [31:0] acc_pp;
    logic [1:0]  acc_step;
    logic        acc_en;
    logic        mul_last;

    if (PIPE_MULT != 0) begin : g_pipe
        logic [31:0] pp_q;
        logic [1:0]  pp_step_q;
        logic        pp_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pp_q      <= '0;
                pp_step_q <= '0;
                pp_vld_q  <= 1'b0;
            end else begin
                pp_q      <= prod[31:0];
                pp_step_q <= step_q;
                // Stop issuing once the last registered product is being consumed.
                pp_vld_q  <= (state_q == StMul) && !mul_last;
            end
        end

        assign acc_pp   = pp_q;
        assign acc_step = pp_step_q;
        assign acc_en   = pp_vld_q;
        assign mul_last = pp_vld_q && (pp_step_q == 2'd3);
    end else begin : g_nopipe
        assign acc_pp   = prod[31:0];
        assign acc_step = step_q;
        assign acc_en   = 1'b1;
        assign mul_last = (step_q == 2'd3);
    end

    // 64-bit accumulate; the carry out of bit 63 is dropped.
    logic [63:0] acc_sum;
    assign acc_sum = acc_q + pp_align(acc_pp, acc_step);

    // Signed correction for the upper word of the unsigned product.
    logic [31:0] corr;
    assign corr = ((sa_q && a_q[31]) ? b_q : 32'd0) + ((sb_q && b_q[31]) ? a_q : 32'd0);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StMul;
                    step_d  = 2'd0;
                    acc_d   = '0;
                    load    = 1'b1;
                end
            end
            StMul: begin
                step_d = step_q + 2'd1;
                if (acc_en) begin
                    acc_d = acc_sum;
                end
                if (mul_last) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                acc_d   = {acc_q[63:32] - corr, acc_q[31:0]};
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            if (load) begin
                a_q  <= in_a;
                b_q  <= in_b;
                sa_q <= in_a_signed;
                sb_q <= in_b_signed;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_prod  = out_valid ? acc_q : 64'd0;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: one instance per PIPE_MULT setting, exercised in turn.
// Expected products are queued at accept and compared when the result handshakes.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [31:0] in_a        [2];
    logic [31:0] in_b        [2];
    logic        in_a_signed [2];
    logic        in_b_signed [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [63:0] out_prod    [2];
    logic        busy        [2];

    always #5 clk = ~clk;

    mul32_seq #(.PIPE_MULT(0)) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .in_a        (in_a[0]),
        .in_b        (in_b[0]),
        .in_a_signed (in_a_signed[0]),
        .in_b_signed (in_b_signed[0]),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready[0]),
        .out_prod    (out_prod[0]),
        .busy        (busy[0])
    );

    mul32_seq #(.PIPE_MULT(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .in_a        (in_a[1]),
        .in_b        (in_b[1]),
        .in_a_signed (in_a_signed[1]),
        .in_b_signed (in_b_signed[1]),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready[1]),
        .out_prod    (out_prod[1]),
        .busy        (busy[1])
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  [2];
    logic        prev_valid [2];
    logic [63:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", tag, $time);
    endtask

    // Reference: sign- or zero-extend to 64 bits and multiply mod 2^64.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input logic [63:0] exp, output int t);
        @(negedge clk);
        in_valid[p]    = 1'b1;
        in_a[p]        = a;
        in_b[p]        = b;
        in_a_signed[p] = sa;
        in_b_signed[p] = sb;
        t = cyc;
        for (int i = 0; i < 64; i++) begin
            if (in_ready[p]) begin
                @(posedge clk);
                #1;
                in_valid[p] = 1'b0;
                t           = cyc;
                acc_cyc[p]  = cyc;
                exp_q.push_back(exp);
                return;
            end
            @(negedge clk);
        end
        in_valid[p] = 1'b0;
        fail_now("accept_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        fail_now("drain_timeout");
        exp_q.delete();
    endtask

    // Result monitor: latency on the rising edge of out_valid, product on handshake.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_n) begin
                if (out_valid[p] && !prev_valid[p]) begin
                    check($sformatf("latency%0d", p), 64'(cyc - acc_cyc[p]), 64'(5 + p));
                end
                if (out_valid[p] && out_ready[p]) begin
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_result%0d", p));
                    end else begin
                        check($sformatf("prod%0d", p), out_prod[p], exp_q.pop_front());
                    end
                end
            end
            prev_valid[p] <= out_valid[p];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t;
        logic [31:0] ra, rb;
        logic rsa, rsb;

        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            in_valid[p]    = 1'b0;
            in_a[p]        = '0;
            in_b[p]        = '0;
            in_a_signed[p] = 1'b0;
            in_b_signed[p] = 1'b0;
            out_ready[p]   = 1'b1;
            acc_cyc[p]     = 0;
            prev_valid[p]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check("rst_in_ready", 64'(in_ready[p]), 64'd1);
            check("rst_out_valid", 64'(out_valid[p]), 64'd0);
            check("rst_out_prod", out_prod[p], 64'd0);
            check("rst_busy", 64'(busy[p]), 64'd0);
        end
        rst_n = 1'b1;

        for (int p = 0; p < 2; p++) begin
            // Unsigned and signed corner products.
            send(p, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, t);
            drain();
            send(p, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, t);
            send(p, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, t);
            send(p, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, t);
            send(p, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b1, 64'h0000_0002_FFFF_FFFA, t);
            drain();

            // Backpressure, plus an in_valid pulse while busy that must be ignored.
            out_ready[p] = 1'b0;
            send(p, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0,
                 model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0), t);
            @(negedge clk);
            in_valid[p] = 1'b1;
            in_a[p]     = 32'hDEAD_0001;
            in_b[p]     = 32'h0BAD_F00D;
            @(posedge clk);
            #1;
            in_valid[p] = 1'b0;
            for (int i = 0; i < 20 && !out_valid[p]; i++) @(negedge clk);
            if (!out_valid[p]) fail_now("bp_no_result");
            repeat (10) begin
                @(negedge clk);
                check("bp_out_valid", 64'(out_valid[p]), 64'd1);
                check("bp_out_prod", out_prod[p],
                      model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0));
                check("bp_in_ready", 64'(in_ready[p]), 64'd0);
            end
            out_ready[p] = 1'b1;
            drain();

            // Reset during multiply step 2.
            send(p, 32'h0001_2345, 32'h0006_789A, 1'b0, 1'b0, 64'd0, t);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("midrst_out_valid", 64'(out_valid[p]), 64'd0);
            check("midrst_out_prod", out_prod[p], 64'd0);
            check("midrst_in_ready", 64'(in_ready[p]), 64'd1);
            check("midrst_busy", 64'(busy[p]), 64'd0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            send(p, 32'd7, 32'd6, 1'b0, 1'b0, 64'h2A, t);
            drain();

            // Back-to-back with out_ready held high.
            send(p, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, t1);
            send(p, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0, t2);
            check("interval", 64'(t2 - t1), 64'(7 + p));
            drain();

            // Random operands and sign modes against the reference model.
            for (int i = 0; i < 8; i++) begin
                ra  = $urandom;
                rb  = $urandom;
                rsa = 1'($urandom_range(1));
                rsb = 1'($urandom_range(1));
                send(p, ra, rb, rsa, rsb, model(ra, rb, rsa, rsb), t);
            end
            drain();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
